// File: rtl/mem_arbiter.sv
// ============================================================================
// mem_arbiter
//
// Shares one single-port synchronous 8-bit RAM between the CPU core bus and
// the DMA master (SD-card block transfer engine). Each access runs through a
// four-state sequencer (IDLE -> ADDR -> DATA -> ACK). The winner's read data
// and a one-cycle acknowledge go back to that requester only.
//
// Arbitration:
//   - default      : round-robin between CPU and DMA. The pointer resets to
//                    favour the CPU. A DMA burst lock (dma_lock) keeps DMA
//                    on the bus for up to BURST_MAX grants, then forces one
//                    CPU slot.
//   - MEM_ARBITER_DMA_PRIO_EN defined : DMA has strict priority. The burst
//                    counter still forces one CPU slot per BURST_MAX DMA
//                    grants, whether or not dma_lock is set.
//
// Parameters:
//   AW        address width in bits
//   BURST_MAX DMA grants in a row before a waiting CPU is served
//
// Ports:
//   clock, resetn           clock and asynchronous active-low reset
//   cpu_req/we/addr/wdata   CPU request; held until cpu_ack
//   cpu_rdata, cpu_ack      CPU read data, valid with the one-cycle ack
//   dma_req/we/addr/wdata   DMA request; held until dma_ack
//   dma_rdata, dma_ack      DMA read data, valid with the one-cycle ack
//   dma_lock                DMA asks to keep the bus across requests
//   mem_addr/wdata/we       registered RAM port-A controls
//   mem_rdata               RAM q, valid one cycle after the address
//   owner                   0 = CPU, 1 = DMA (current or last grant)
//   busy                    sequencer is not in IDLE
// ============================================================================
module mem_arbiter #(
   parameter int AW        = 18,
   parameter int BURST_MAX = 16
) (
   input  logic          clock,
   input  logic          resetn,

   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [7:0]    cpu_wdata,
   output logic [7:0]    cpu_rdata,
   output logic          cpu_ack,

   input  logic          dma_req,
   input  logic          dma_we,
   input  logic [AW-1:0] dma_addr,
   input  logic [7:0]    dma_wdata,
   output logic [7:0]    dma_rdata,
   output logic          dma_ack,
   input  logic          dma_lock,

   output logic [AW-1:0] mem_addr,
   output logic [7:0]    mem_wdata,
   output logic          mem_we,
   input  logic [7:0]    mem_rdata,

   output logic          owner,
   output logic          busy
);

   localparam int              CW        = $clog2(BURST_MAX + 1);
   localparam logic [CW-1:0]   BURST_LIM = CW'(BURST_MAX);
   localparam logic [CW-1:0]   CNT_ONE   = CW'(1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ADDR = 2'd1,
      S_DATA = 2'd2,
      S_ACK  = 2'd3
   } state_t;

   state_t          state_q,     state_d;
   logic [AW-1:0]   mem_addr_q,  mem_addr_d;
   logic [7:0]      mem_wdata_q, mem_wdata_d;
   logic            mem_we_q,    mem_we_d;
   logic            op_we_q,     op_we_d;      // direction of the access in flight
   logic            owner_q,     owner_d;
   logic            favour_q,    favour_d;     // round-robin pointer: 1 = DMA next
   logic [CW-1:0]   burst_q,     burst_d;      // consecutive DMA grants
   logic [7:0]      cpu_rdata_q, cpu_rdata_d;
   logic [7:0]      dma_rdata_q, dma_rdata_d;
   logic            cpu_ack_q,   cpu_ack_d;
   logic            dma_ack_q,   dma_ack_d;

   logic            burst_full;
   logic            pick_dma;

   // Saturating increment keeps the counter pinned at the limit while DMA
   // runs alone, so a CPU that arrives later is served on its first try.
   function automatic logic [CW-1:0] burst_inc(input logic [CW-1:0] v);
      return (v >= BURST_LIM) ? BURST_LIM : v + CNT_ONE;
   endfunction

   // Winner selection, resolved combinationally in the IDLE cycle.
   always_comb begin
      burst_full = (burst_q >= BURST_LIM);
      pick_dma   = 1'b0;
      if (dma_req && !cpu_req) begin
         pick_dma = 1'b1;
      end else if (dma_req && cpu_req) begin
         if (burst_full) begin
            pick_dma = 1'b0;
         end else begin
`ifdef MEM_ARBITER_DMA_PRIO_EN
            pick_dma = 1'b1;
`else
            pick_dma = dma_lock ? 1'b1 : favour_q;
`endif
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_we_d    = 1'b0;
      op_we_d     = op_we_q;
      owner_d     = owner_q;
      favour_d    = favour_q;
      burst_d     = burst_q;
      cpu_rdata_d = cpu_rdata_q;
      dma_rdata_d = dma_rdata_q;
      cpu_ack_d   = 1'b0;
      dma_ack_d   = 1'b0;

      case (state_q)
         // IDLE: grant and latch the winner's transaction into the RAM port.
         S_IDLE: begin
            if (cpu_req || dma_req) begin
               owner_d     = pick_dma;
               favour_d    = ~pick_dma;
               mem_addr_d  = pick_dma ? dma_addr  : cpu_addr;
               mem_wdata_d = pick_dma ? dma_wdata : cpu_wdata;
               mem_we_d    = pick_dma ? dma_we    : cpu_we;
               op_we_d     = pick_dma ? dma_we    : cpu_we;
               state_d     = S_ADDR;
               if (pick_dma) begin
`ifdef MEM_ARBITER_DMA_PRIO_EN
                  burst_d = burst_inc(burst_q);
`else
                  burst_d = dma_lock ? burst_inc(burst_q) : '0;
`endif
               end else begin
                  burst_d = '0;
               end
            end else begin
`ifdef MEM_ARBITER_DMA_PRIO_EN
               burst_d = burst_q;
`else
               if (!dma_lock) begin
                  burst_d = '0;
               end
`endif
            end
         end

         // ADDR: the RAM samples address/we at the closing edge.
         S_ADDR: begin
            state_d = S_DATA;
         end

         // DATA: RAM q is valid; capture it for the owner on a read.
         S_DATA: begin
            if (!op_we_q) begin
               if (owner_q) begin
                  dma_rdata_d = mem_rdata;
               end else begin
                  cpu_rdata_d = mem_rdata;
               end
            end
            cpu_ack_d = ~owner_q;
            dma_ack_d = owner_q;
            state_d   = S_ACK;
         end

         // ACK: the owner's ack is high for this cycle only.
         S_ACK: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q     <= S_IDLE;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_we_q    <= 1'b0;
         op_we_q     <= 1'b0;
         owner_q     <= 1'b0;
         favour_q    <= 1'b0;
         burst_q     <= '0;
         cpu_rdata_q <= '0;
         dma_rdata_q <= '0;
         cpu_ack_q   <= 1'b0;
         dma_ack_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_we_q    <= mem_we_d;
         op_we_q     <= op_we_d;
         owner_q     <= owner_d;
         favour_q    <= favour_d;
         burst_q     <= burst_d;
         cpu_rdata_q <= cpu_rdata_d;
         dma_rdata_q <= dma_rdata_d;
         cpu_ack_q   <= cpu_ack_d;
         dma_ack_q   <= dma_ack_d;
      end
   end

   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_we    = mem_we_q;
   assign owner     = owner_q;
   assign busy      = (state_q != S_IDLE);
   assign cpu_rdata = cpu_rdata_q;
   assign dma_rdata = dma_rdata_q;
   assign cpu_ack   = cpu_ack_q;
   assign dma_ack   = dma_ack_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter (AW=18, BURST_MAX=4).
// The RAM model fills every location with (index[7:0] ^ 8'h3C), using
// address bits [9:0] as the index, so unwritten reads have known values:
//   0x00010 -> 0x2C, 0x00020 -> 0x1C, 0x3FFFF -> 0xC3, 0x00000 -> 0x3C.
module tb_mem_arbiter;

   logic        clock;
   logic        resetn;
   logic        cpu_req, cpu_we;
   logic [17:0] cpu_addr;
   logic [7:0]  cpu_wdata, cpu_rdata;
   logic        cpu_ack;
   logic        dma_req, dma_we;
   logic [17:0] dma_addr;
   logic [7:0]  dma_wdata, dma_rdata;
   logic        dma_ack, dma_lock;
   logic [17:0] mem_addr;
   logic [7:0]  mem_wdata, mem_rdata;
   logic        mem_we, owner, busy;

   int errors = 0;
   int checks = 0;

   mem_arbiter #(.AW(18), .BURST_MAX(4)) dut (
      .clock     (clock),
      .resetn    (resetn),
      .cpu_req   (cpu_req),
      .cpu_we    (cpu_we),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_rdata (cpu_rdata),
      .cpu_ack   (cpu_ack),
      .dma_req   (dma_req),
      .dma_we    (dma_we),
      .dma_addr  (dma_addr),
      .dma_wdata (dma_wdata),
      .dma_rdata (dma_rdata),
      .dma_ack   (dma_ack),
      .dma_lock  (dma_lock),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_we    (mem_we),
      .mem_rdata (mem_rdata),
      .owner     (owner),
      .busy      (busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Single-port synchronous RAM model plus a write-strobe counter.
   logic [7:0] ram [0:1023];
   logic       ram_init = 1'b0;
   int         we_cnt   = 0;
   always @(posedge clock) begin
      if (!ram_init) begin
         for (int i = 0; i < 1024; i++) ram[i] <= 8'(i) ^ 8'h3C;
         ram_init <= 1'b1;
      end else if (mem_we) begin
         ram[mem_addr[9:0]] <= mem_wdata;
      end
      mem_rdata <= ram[mem_addr[9:0]];
      if (mem_we) we_cnt <= we_cnt + 1;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      step();
      step();
      resetn = 1'b1;
      step();
   endtask

   // Both sides keep requesting reads; seq bit k = 1 means DMA wins grant k.
   task automatic run_grants(input string tag, input logic [15:0] seq, input int n);
      for (int k = 0; k < n; k++) begin
         step();                                   // cycle 4k+1
         chk({tag, "_owner"}, 32'(owner), 32'(seq[k]));
         chk({tag, "_busy"},  32'(busy),  32'd1);
         step();
         step();                                   // cycle 4k+3
         chk({tag, "_cpu_ack"}, 32'(cpu_ack), 32'(!seq[k]));
         chk({tag, "_dma_ack"}, 32'(dma_ack), 32'(seq[k]));
         if (seq[k]) chk({tag, "_dma_rdata"}, 32'(dma_rdata), 32'h1C);
         else        chk({tag, "_cpu_rdata"}, 32'(cpu_rdata), 32'h2C);
         step();                                   // next IDLE cycle
      end
   endtask

   initial begin
      int we_base;
      resetn    = 1'b0;
      cpu_req   = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      dma_req   = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
      dma_lock  = 1'b0;
      #1;
      chk("rst_mem_we",  32'(mem_we),    32'd0);
      chk("rst_busy",    32'(busy),      32'd0);
      chk("rst_owner",   32'(owner),     32'd0);
      chk("rst_cpu_ack", 32'(cpu_ack),   32'd0);
      chk("rst_dma_ack", 32'(dma_ack),   32'd0);
      chk("rst_addr",    32'(mem_addr),  32'd0);
      chk("rst_wdata",   32'(mem_wdata), 32'd0);
      chk("rst_cpu_rd",  32'(cpu_rdata), 32'd0);
      chk("rst_dma_rd",  32'(dma_rdata), 32'd0);
      step();
      step();
      resetn = 1'b1;
      step();

      // CPU write 0x5A to 0x01234, then read it back.
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 18'h01234; cpu_wdata = 8'h5A;
      step();                                      // cycle 1
      chk("wr_mem_we",    32'(mem_we),    32'd1);
      chk("wr_mem_addr",  32'(mem_addr),  32'h01234);
      chk("wr_mem_wdata", 32'(mem_wdata), 32'h5A);
      chk("wr_busy",      32'(busy),      32'd1);
      chk("wr_owner",     32'(owner),     32'd0);
      step();                                      // cycle 2
      chk("wr_mem_we_c2", 32'(mem_we),    32'd0);
      chk("wr_ack_c2",    32'(cpu_ack),   32'd0);
      step();                                      // cycle 3
      chk("wr_ack_c3",    32'(cpu_ack),   32'd1);
      chk("wr_dma_ack",   32'(dma_ack),   32'd0);
      chk("wr_rdata_hold",32'(cpu_rdata), 32'd0);
      cpu_we = 1'b0;                               // new transaction: read back
      step();                                      // cycle 4
      chk("rd_ack_c4",    32'(cpu_ack),   32'd0);
      chk("rd_busy_c4",   32'(busy),      32'd0);
      step();                                      // cycle 5
      chk("rd_mem_we",    32'(mem_we),    32'd0);
      chk("rd_mem_addr",  32'(mem_addr),  32'h01234);
      step();
      step();                                      // cycle 7
      chk("rd_ack",       32'(cpu_ack),   32'd1);
      chk("rd_rdata",     32'(cpu_rdata), 32'h5A);
      cpu_req = 1'b0;
      step();

      // Contention from reset, unlocked.
      do_reset();
      we_base  = we_cnt;
      cpu_req  = 1'b1; cpu_we = 1'b0; cpu_addr = 18'h00010;
      dma_req  = 1'b1; dma_we = 1'b0; dma_addr = 18'h00020;
      dma_lock = 1'b0;
`ifdef MEM_ARBITER_DMA_PRIO_EN
      run_grants("prio", 16'b1110_1111, 8);
`else
      run_grants("rr", 16'b1010_1010, 8);
`endif
      cpu_req = 1'b0; dma_req = 1'b0;
      step();
      chk("cont_no_writes", 32'(we_cnt - we_base), 32'd0);

      // Burst lock with CPU requesting continuously.
      do_reset();
      cpu_req  = 1'b1; dma_req = 1'b1; dma_lock = 1'b1;
      run_grants("lock", 16'b01_1110_1111, 10);
      cpu_req = 1'b0; dma_req = 1'b0; dma_lock = 1'b0;
      step();

      // Back-to-back DMA reads with address wrap.
      do_reset();
      we_base  = we_cnt;
      dma_req  = 1'b1; dma_we = 1'b0; dma_addr = 18'h3FFFF;
      step();                                      // cycle 1
      chk("b2b_addr0",  32'(mem_addr),  32'h3FFFF);
      chk("b2b_owner",  32'(owner),     32'd1);
      step();
      step();                                      // cycle 3
      chk("b2b_ack0",   32'(dma_ack),   32'd1);
      chk("b2b_rdata0", 32'(dma_rdata), 32'hC3);
      dma_addr = 18'h00000;
      step();                                      // cycle 4
      chk("b2b_ack_c4", 32'(dma_ack),   32'd0);
      step();                                      // cycle 5
      chk("b2b_addr1",  32'(mem_addr),  32'h00000);
      step();
      step();                                      // cycle 7
      chk("b2b_ack1",   32'(dma_ack),   32'd1);
      chk("b2b_rdata1", 32'(dma_rdata), 32'h3C);
      chk("b2b_cpu_ack",32'(cpu_ack),   32'd0);
      dma_req = 1'b0;
      step();
      chk("b2b_no_writes", 32'(we_cnt - we_base), 32'd0);

      // Reset during ADDR of a DMA write.
      dma_req = 1'b1; dma_we = 1'b1; dma_addr = 18'h00100; dma_wdata = 8'h77;
      step();                                      // cycle 1 (ADDR)
      chk("mid_mem_we", 32'(mem_we), 32'd1);
      #2;
      resetn = 1'b0;
      #1;
      chk("mid_rst_we",    32'(mem_we),    32'd0);
      chk("mid_rst_busy",  32'(busy),      32'd0);
      chk("mid_rst_owner", 32'(owner),     32'd0);
      chk("mid_rst_addr",  32'(mem_addr),  32'd0);
      chk("mid_rst_wdata", 32'(mem_wdata), 32'd0);
      chk("mid_rst_dmard", 32'(dma_rdata), 32'd0);
      chk("mid_rst_ack",   32'(dma_ack),   32'd0);
      dma_req = 1'b0;
      step();
      resetn = 1'b1;
      for (int c = 0; c < 4; c++) begin
         step();
         chk("mid_post_busy", 32'(busy),    32'd0);
         chk("mid_post_ack",  32'(dma_ack), 32'd0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
